// File: rtl/transmitter_wrapper.sv
// Buffered UART transmitter: a valid/ready byte FIFO in distributed RAM feeding an 8N1 serialiser.
// The serial line is driven from a register and idles high.
module transmitter_wrapper #(
  parameter int WIDTH       = 12,
  parameter int CLK_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] in,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       busy
);

  localparam int DEPTH = 2 ** WIDTH;
  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             out_n;

  logic [WIDTH-1:0] in_pointer, out_pointer;
  logic [7:0]       buffer [DEPTH];
  logic             empty, full, push, pop, bit_end;

  assign empty   = (in_pointer == out_pointer);
  assign full    = ((in_pointer + WIDTH'(1)) == out_pointer);
  assign ready   = !full;
  assign push    = valid && !full;
  assign pop     = (state == IDLE) && !empty;
  assign busy    = !empty || (state != IDLE);
  assign bit_end = (cnt == CNT_LAST);

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge CLK) begin
    if (push) buffer[in_pointer] <= in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_pointer  <= '0;
      out_pointer <= '0;
    end else begin
      if (push) in_pointer  <= in_pointer + WIDTH'(1);
      if (pop)  out_pointer <= out_pointer + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      out   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      out   <= out_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n = START;
          cnt_n   = '0;
          shift_n = buffer[out_pointer];
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is computed from the next state so the registered output lines up with it.
  always_comb begin
    out_n = 1'b1;
    case (state_n)
      START:   out_n = 1'b0;
      DATA:    out_n = shift_n[idx_n];
      default: out_n = 1'b1;
    endcase
  end

endmodule
